// File: rtl/load_seq_pkg.sv
// load_seq_pkg: shared definitions for the memory load sequencer.
//   state_t            - sequencer FSM states (CLEAR only when ZERO_FILL_EN is defined)
//   KERNEL_TAG         - address bit that selects the kernel region of the memory
//   *_ADDR_BITS        - counter bits forwarded to the address per phase
//   CNT_WIDTH          - word counter width (wide enough for the largest phase)
// Configuration macro: ZERO_FILL_EN (adds the CLEAR state).
package load_seq_pkg;

   localparam int KERNEL_TAG        = 15;
   localparam int KERNEL_ADDR_BITS  = 9;
   localparam int INPUT_ADDR_BITS   = 14;
   localparam int OVERLAP_ADDR_BITS = 8;
   localparam int CNT_WIDTH         = INPUT_ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
`ifdef ZERO_FILL_EN
      S_CLEAR,
`endif
      S_LOAD_KERNEL,
      S_LOAD_INPUT,
      S_LOAD_OVERLAP,
      S_COMPUTE,
      S_FINISH
   } state_t;

endpackage

// File: rtl/phase_counter.sv
// phase_counter: word counter for one load phase.
//   clk, arst_n : clock and asynchronous active-low reset
//   clr         : synchronous clear (wins over inc)
//   inc         : count one word
//   limit       : last count value of the current phase
//   cnt         : current word index
//   tc          : cnt has reached limit
module phase_counter
   import load_seq_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + WIDTH'(1);
   end

   assign tc = (cnt == limit);

endmodule

// File: rtl/mem_load_sequencer.sv
// mem_load_sequencer: streams kernel, input-feature and overlap words from the
// host into on-chip memories, tile by tile, handing each tile to compute.
//   clk, arst_n_in          : clock, asynchronous active-low reset
//   start                   : run request (honoured in IDLE only)
//   src_data/valid/ready    : host word stream
//   a_input, b_input        : memory write address / data (zero when not writing)
//   int_mem_we              : input/kernel memory write enable
//   overlap_cache_we        : overlap cache write enable
//   b_zero                  : force write data to zero (zero-fill sweep)
//   data_ready, fsm_done    : tile handshake with the compute controller
//   busy, run_done, tile_idx: run status
// Configuration macro: ZERO_FILL_EN (zero-fill sweep of the input memory per run).
module mem_load_sequencer
   import load_seq_pkg::*;
#(
   parameter int IO_DATA_WIDTH = 16,
   parameter int KERNEL_WORDS  = 512,
   parameter int INPUT_WORDS   = 16384,
   parameter int OVERLAP_WORDS = 256,
   parameter int NB_TILES      = 4
) (
   input  logic                     clk,
   input  logic                     arst_n_in,
   input  logic                     start,
   input  logic [IO_DATA_WIDTH-1:0] src_data,
   input  logic                     src_valid,
   output logic                     src_ready,
   output logic [IO_DATA_WIDTH-1:0] a_input,
   output logic [IO_DATA_WIDTH-1:0] b_input,
   output logic                     int_mem_we,
   output logic                     overlap_cache_we,
   output logic                     b_zero,
   output logic                     data_ready,
   input  logic                     fsm_done,
   output logic                     busy,
   output logic                     run_done,
   output logic [7:0]               tile_idx
);

   state_t               state;
   logic [7:0]           tile_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] limit;
   logic                 loading;
   logic                 accept;
   logic                 cnt_inc;
   logic                 cnt_clr;
   logic                 tc;
   logic                 last;

   always_comb begin
      limit   = '0;
      loading = 1'b0;
      case (state)
`ifdef ZERO_FILL_EN
         S_CLEAR:        limit = CNT_WIDTH'(INPUT_WORDS - 1);
`endif
         S_LOAD_KERNEL:  begin limit = CNT_WIDTH'(KERNEL_WORDS - 1);  loading = 1'b1; end
         S_LOAD_INPUT:   begin limit = CNT_WIDTH'(INPUT_WORDS - 1);   loading = 1'b1; end
         S_LOAD_OVERLAP: begin limit = CNT_WIDTH'(OVERLAP_WORDS - 1); loading = 1'b1; end
         default:        ;
      endcase
   end

   assign accept = loading & src_valid;

`ifdef ZERO_FILL_EN
   // The sweep advances every cycle, independent of the host stream.
   assign cnt_inc = accept | (state == S_CLEAR);
`else
   assign cnt_inc = accept;
`endif

   assign last    = cnt_inc & tc;
   // Counter is already zero on every COMPUTE exit, so only start and phase ends clear it.
   assign cnt_clr = ((state == S_IDLE) & start) | last;

   phase_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk    (clk),
      .arst_n (arst_n_in),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .limit  (limit),
      .cnt    (cnt),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state  <= S_IDLE;
         tile_q <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (start) begin
                  tile_q <= '0;
`ifdef ZERO_FILL_EN
                  state  <= S_CLEAR;
`else
                  state  <= S_LOAD_KERNEL;
`endif
               end
`ifdef ZERO_FILL_EN
            S_CLEAR:        if (last) state <= S_LOAD_KERNEL;
`endif
            S_LOAD_KERNEL:  if (last) state <= S_LOAD_INPUT;
            S_LOAD_INPUT:   if (last) state <= S_LOAD_OVERLAP;
            S_LOAD_OVERLAP: if (last) state <= S_COMPUTE;
            S_COMPUTE:
               if (fsm_done) begin
                  if (tile_q == 8'(NB_TILES - 1)) begin
                     state <= S_FINISH;
                  end else begin
                     // Kernels stay resident; next tile reloads input and overlap only.
                     tile_q <= tile_q + 8'd1;
                     state  <= S_LOAD_INPUT;
                  end
               end
            S_FINISH:       state <= S_IDLE;
            default:        state <= S_IDLE;
         endcase
      end
   end

   // Write port is combinational so the write lands in the accept cycle.
   always_comb begin
      a_input          = '0;
      b_input          = '0;
      int_mem_we       = 1'b0;
      overlap_cache_we = 1'b0;
      b_zero           = 1'b0;
      case (state)
`ifdef ZERO_FILL_EN
         S_CLEAR: begin
            a_input[INPUT_ADDR_BITS-1:0] = cnt[INPUT_ADDR_BITS-1:0];
            int_mem_we                   = 1'b1;
            b_zero                       = 1'b1;
         end
`endif
         S_LOAD_KERNEL:
            if (accept) begin
               a_input[KERNEL_ADDR_BITS-1:0] = cnt[KERNEL_ADDR_BITS-1:0];
               a_input[KERNEL_TAG]           = 1'b1;
               b_input                       = src_data;
               int_mem_we                    = 1'b1;
            end
         S_LOAD_INPUT:
            if (accept) begin
               a_input[INPUT_ADDR_BITS-1:0] = cnt[INPUT_ADDR_BITS-1:0];
               b_input                      = src_data;
               int_mem_we                   = 1'b1;
            end
         S_LOAD_OVERLAP:
            if (accept) begin
               a_input[OVERLAP_ADDR_BITS-1:0] = cnt[OVERLAP_ADDR_BITS-1:0];
               b_input                        = src_data;
               overlap_cache_we               = 1'b1;
            end
         default: ;
      endcase
   end

   assign src_ready  = loading;
   assign busy       = (state != S_IDLE);
   assign data_ready = (state == S_COMPUTE);
   assign run_done   = (state == S_FINISH);
   assign tile_idx   = tile_q;

endmodule

// File: tb/tb_mem_load_sequencer.sv
// tb_mem_load_sequencer: self-checking bench for mem_load_sequencer with small
// phase sizes. Expected writes come from a queue of (region, address) entries
// built per run/tile; every cycle the DUT outputs are compared with it.
// Honours ZERO_FILL_EN by expecting the zero-fill sweep after each start.
module tb_mem_load_sequencer;

   localparam int KW = 4;
   localparam int IW = 8;
   localparam int OW = 2;
   localparam int NT = 2;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        start;
   logic [15:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [15:0] a_input;
   logic [15:0] b_input;
   logic        int_mem_we;
   logic        overlap_cache_we;
   logic        b_zero;
   logic        data_ready;
   logic        fsm_done;
   logic        busy;
   logic        run_done;
   logic [7:0]  tile_idx;

   always #5 clk = ~clk;

   mem_load_sequencer #(
      .IO_DATA_WIDTH (16),
      .KERNEL_WORDS  (KW),
      .INPUT_WORDS   (IW),
      .OVERLAP_WORDS (OW),
      .NB_TILES      (NT)
   ) dut (
      .clk              (clk),
      .arst_n_in        (arst_n_in),
      .start            (start),
      .src_data         (src_data),
      .src_valid        (src_valid),
      .src_ready        (src_ready),
      .a_input          (a_input),
      .b_input          (b_input),
      .int_mem_we       (int_mem_we),
      .overlap_cache_we (overlap_cache_we),
      .b_zero           (b_zero),
      .data_ready       (data_ready),
      .fsm_done         (fsm_done),
      .busy             (busy),
      .run_done         (run_done),
      .tile_idx         (tile_idx)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: pending writes as {overlap_region, address}.
   logic [16:0] exp_q[$];
   logic        m_busy;
   logic        m_compute;
   logic        m_finish;
   int          m_clear;
   logic [7:0]  m_tile;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy    = 1'b0;
      m_compute = 1'b0;
      m_finish  = 1'b0;
      m_clear   = 0;
      m_tile    = '0;
   endtask

   task automatic push_kernel();
      for (int i = 0; i < KW; i++) exp_q.push_back({1'b0, 16'h8000 | 16'(i)});
   endtask

   task automatic push_tile();
      for (int i = 0; i < IW; i++) exp_q.push_back({1'b0, 16'(i)});
      for (int i = 0; i < OW; i++) exp_q.push_back({1'b1, 16'(i)});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_src_ready"}, 32'(src_ready), 0);
      chk({tag, "_a_input"},   32'(a_input), 0);
      chk({tag, "_b_input"},   32'(b_input), 0);
      chk({tag, "_int_we"},    32'(int_mem_we), 0);
      chk({tag, "_ovl_we"},    32'(overlap_cache_we), 0);
      chk({tag, "_b_zero"},    32'(b_zero), 0);
      chk({tag, "_data_rdy"},  32'(data_ready), 0);
      chk({tag, "_busy"},      32'(busy), 0);
      chk({tag, "_run_done"},  32'(run_done), 0);
      chk({tag, "_tile_idx"},  32'(tile_idx), 0);
   endtask

   // One clock: drive at negedge, compare 1 time unit later, then advance the model.
   task automatic cycle(input logic v, input logic [15:0] d, input logic st, input logic fd);
      logic [16:0] w;
      logic        loading;
      logic [15:0] e_a;
      logic [15:0] e_b;
      logic        e_we;
      logic        e_ow;
      logic        e_bz;
      @(negedge clk);
      src_valid = v;
      src_data  = d;
      start     = st;
      fsm_done  = fd;
      #1;
      loading = m_busy && (m_clear == 0) && (exp_q.size() > 0);
      e_a  = '0;
      e_b  = '0;
      e_we = 1'b0;
      e_ow = 1'b0;
      e_bz = 1'b0;
      if (m_busy && m_clear > 0) begin
         e_a  = 16'(IW - m_clear);
         e_we = 1'b1;
         e_bz = 1'b1;
      end else if (loading && v) begin
         w    = exp_q[0];
         e_a  = w[15:0];
         e_b  = d;
         e_we = ~w[16];
         e_ow = w[16];
      end
      chk("src_ready",  32'(src_ready),        32'(loading));
      chk("a_input",    32'(a_input),          32'(e_a));
      chk("b_input",    32'(b_input),          32'(e_b));
      chk("int_mem_we", 32'(int_mem_we),       32'(e_we));
      chk("ovl_we",     32'(overlap_cache_we), 32'(e_ow));
      chk("b_zero",     32'(b_zero),           32'(e_bz));
      chk("data_ready", 32'(data_ready),       32'(m_compute));
      chk("busy",       32'(busy),             32'(m_busy));
      chk("run_done",   32'(run_done),         32'(m_finish));
      chk("tile_idx",   32'(tile_idx),         32'(m_tile));
      if (!m_busy) begin
         if (st) begin
            m_busy = 1'b1;
            m_tile = '0;
            push_kernel();
            push_tile();
`ifdef ZERO_FILL_EN
            m_clear = IW;
`endif
         end
      end else if (m_finish) begin
         m_finish = 1'b0;
         m_busy   = 1'b0;
      end else if (m_clear > 0) begin
         m_clear--;
      end else if (loading) begin
         if (v) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_compute = 1'b1;
         end
      end else if (m_compute && fd) begin
         m_compute = 1'b0;
         if (m_tile == 8'(NT - 1)) begin
            m_finish = 1'b1;
         end else begin
            m_tile++;
            push_tile();
         end
      end
   endtask

   task automatic sweep_if_enabled();
`ifdef ZERO_FILL_EN
      // src_valid held high: the sweep must not consume host words.
      for (int i = 0; i < IW; i++) cycle(1'b1, 16'hffff, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      arst_n_in = 1'b0;
      start     = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      fsm_done  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk_all_zero("reset");
      arst_n_in = 1'b1;
      cycle(1'b1, 16'h1234, 1'b0, 1'b0);   // idle: src_valid ignored

      // Run 1: continuous stream, data 1..14
      cycle(1'b0, '0, 1'b1, 1'b0);
      sweep_if_enabled();
      for (int i = 1; i <= 14; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);         // compute, data_ready
      cycle(1'b0, '0, 1'b1, 1'b0);         // start in compute ignored
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);         // done tile 0 -> tile 1
      cycle(1'b0, '0, 1'b0, 1'b1);         // done while loading ignored
      for (int k = 0; k < 200 && exp_q.size() > 0; k++)
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0);
      chk("tile1_budget", 32'(exp_q.size()), 0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);         // done last tile -> finish
      cycle(1'b0, '0, 1'b0, 1'b0);         // run_done pulse
      cycle(1'b0, '0, 1'b0, 1'b0);         // back to idle
      cycle(1'b0, '0, 1'b0, 1'b0);

      // Run 2: valid on every other cycle, 14 words over 28 cycles
      cycle(1'b0, '0, 1'b1, 1'b0);
      sweep_if_enabled();
      for (int i = 0; i < 28; i++) cycle(1'((i % 2) == 0), 16'($urandom), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);         // tile 1
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);

      // Reset while the 5th input word is being written
      @(negedge clk);
      src_valid = 1'b1;
      src_data  = 16'hbeef;
      #1;
      chk("pre_reset_addr", 32'(a_input), 32'(exp_q[0][15:0]));
      chk("pre_reset_we",   32'(int_mem_we), 1);
      arst_n_in = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      model_reset();
      @(negedge clk);
      src_valid = 1'b0;
      arst_n_in = 1'b1;
      cycle(1'b0, '0, 1'b1, 1'b0);
      sweep_if_enabled();
      for (int i = 0; i < 6; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
